divclk_prog: RTL and testbench

//  Runtime-programmable clock/tick divider; successor to the fixed-divisor divider.

---
 rtl/divclk_pkg.sv | 10 +
 rtl/divclk_shadow.sv | 53 +++++
 rtl/divclk_prog.sv | 87 ++++++++
 tb/tb_divclk_prog.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/divclk_pkg.sv
// Shared constants and the divisor clamp for the programmable clock divider.
package divclk_pkg;
  localparam int          CNT_W_DEF = 16;
  localparam logic [31:0] DIV_MIN   = 32'd2;

  // A divisor below 2 cannot produce both a high and a low phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction
endpackage

// File: rtl/divclk_shadow.sv
// Divisor capture: clamps div_in, holds a shadow while running and applies it
// only at a period boundary (or when the divider is stopped).
module divclk_shadow
  import divclk_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_RESET = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             apply,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic [CNT_W-1:0] div_cur,
  output logic             load_pend
);
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             load_pend_q, load_pend_d;
  logic [CNT_W-1:0] div_clamped;

  assign div_clamped = CNT_W'(clamp_div(32'(div_in)));

  always_comb begin
    div_cur_d   = div_cur_q;
    shadow_d    = shadow_q;
    load_pend_d = load_pend_q;
    if (apply) begin
      // A strobe coinciding with the boundary is newer than the shadow.
      load_pend_d = 1'b0;
      if (div_load)         div_cur_d = div_clamped;
      else if (load_pend_q) div_cur_d = shadow_q;
    end else if (div_load) begin
      shadow_d    = div_clamped;
      load_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_cur_q   <= CNT_W'(DIV_RESET);
      shadow_q    <= CNT_W'(DIV_RESET);
      load_pend_q <= 1'b0;
    end else begin
      div_cur_q   <= div_cur_d;
      shadow_q    <= shadow_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign div_cur   = div_cur_q;
  assign load_pend = load_pend_q;
endmodule

// File: rtl/divclk_prog.sv
// Runtime-programmable divider: period counter, run flag and registered
// clk_out / tick / mid_tick decoded from the next count value.
module divclk_prog
  import divclk_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_RESET = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             mid_tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             load_pend
);
  logic [CNT_W-1:0] count_q, count_d;
  logic             running_q, running_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             boundary, wrap, apply;
  logic [CNT_W-1:0] half;

  assign half = div_cur >> 1;
  assign wrap = (count_q == div_cur - CNT_W'(1));

  always_comb begin
    count_d    = count_q;
    running_d  = running_q;
    clk_out_d  = 1'b0;
    tick_d     = 1'b0;
    mid_tick_d = 1'b0;
    boundary   = 1'b0;
    if (!en) begin
      count_d   = '0;
      running_d = 1'b0;
    end else if (!running_q || restart || wrap) begin
      // Start, restart and wrap all open a fresh period at count 0.
      boundary  = 1'b1;
      running_d = 1'b1;
      count_d   = '0;
      tick_d    = 1'b1;
      clk_out_d = 1'b1;
    end else begin
      count_d    = count_q + CNT_W'(1);
      mid_tick_d = (count_d == half);
      clk_out_d  = (count_d < half);
    end
  end

  assign apply = !en || boundary;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      running_q  <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      running_q  <= running_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  divclk_shadow #(.CNT_W(CNT_W), .DIV_RESET(DIV_RESET)) u_shadow (
    .clk_in    (clk_in),
    .rst       (rst),
    .apply     (apply),
    .div_load  (div_load),
    .div_in    (div_in),
    .div_cur   (div_cur),
    .load_pend (load_pend)
  );

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign mid_tick = mid_tick_q;
endmodule

// File: tb/tb_divclk_prog.sv
// Directed bench for divclk_prog: period shape, deferred divisor loads,
// restart, clamp, stop and asynchronous reset.
module tb_divclk_prog;
  localparam int CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             rst, en, restart, div_load;
  logic [CNT_W-1:0] div_in;
  logic             clk_out, tick, mid_tick, load_pend;
  logic [CNT_W-1:0] div_cur;

  int n_vec = 0;
  int n_err = 0;
  int ph, d, d_next;

  always #5 clk_in = ~clk_in;

  divclk_prog #(.CNT_W(CNT_W), .DIV_RESET(10)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .restart(restart),
    .div_in(div_in), .div_load(div_load), .clk_out(clk_out), .tick(tick),
    .mid_tick(mid_tick), .div_cur(div_cur), .load_pend(load_pend)
  );

  // Expected {tick, mid_tick, clk_out} at phase p of a period of length dv.
  function automatic logic [2:0] exp_pat(input int p, input int dv);
    return {p == 0, p == dv / 2, p < dv / 2};
  endfunction

  // One clock edge plus the reference phase advance; sampling is 1 ns after the edge.
  task automatic edge_adv();
    @(posedge clk_in); #1;
    if (ph == d - 1) begin ph = 0; d = d_next; end
    else ph++;
  endtask

  task automatic raw_edge();
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; restart = 1'b0; div_load = 1'b0; div_in = '0;
    raw_edge(); raw_edge();
    n_vec++;
    if ({tick, mid_tick, clk_out, load_pend} !== 4'b0000 || div_cur !== 16'd10) begin
      n_err++;
      $display("FAIL reset: outs=%b lp=%b div_cur=%0d, want 000/0/10",
               {tick, mid_tick, clk_out}, load_pend, div_cur);
    end
    rst = 1'b0;
    raw_edge();
    n_vec++;
    if ({tick, mid_tick, clk_out} !== 3'b000) begin
      n_err++; $display("FAIL stopped_idle: outs=%b want 000", {tick, mid_tick, clk_out});
    end
  endtask

  task automatic test_div10();
    en = 1'b1;
    raw_edge(); ph = 0; d = 10; d_next = 10;
    for (int i = 0; i < 25; i++) begin
      n_vec++;
      if ({tick, mid_tick, clk_out} !== exp_pat(ph, d)) begin
        n_err++; $display("FAIL div10 ph=%0d: outs=%b want %b", ph, {tick, mid_tick, clk_out}, exp_pat(ph, d));
      end
      edge_adv();
    end
  endtask

  task automatic test_stopped_load();
    en = 1'b0; raw_edge();
    n_vec++;
    if ({tick, mid_tick, clk_out} !== 3'b000) begin
      n_err++; $display("FAIL en_low: outs=%b want 000", {tick, mid_tick, clk_out});
    end
    div_load = 1'b1; div_in = 16'd5; raw_edge(); div_load = 1'b0;
    n_vec++;
    if (div_cur !== 16'd5 || load_pend !== 1'b0) begin
      n_err++; $display("FAIL stopped_load: div_cur=%0d lp=%b want 5/0", div_cur, load_pend);
    end
    en = 1'b1; raw_edge(); ph = 0; d = 5; d_next = 5;
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      if ({tick, mid_tick, clk_out} !== exp_pat(ph, d)) begin
        n_err++; $display("FAIL div5 ph=%0d: outs=%b want %b", ph, {tick, mid_tick, clk_out}, exp_pat(ph, d));
      end
      edge_adv();
    end
  endtask

  task automatic test_deferred_load();
    en = 1'b0; div_load = 1'b1; div_in = 16'd10; raw_edge(); div_load = 1'b0;
    en = 1'b1; raw_edge(); ph = 0; d = 10; d_next = 10;
    for (int i = 0; i < 40 && ph != 3; i++) edge_adv();
    // Two strobes before the boundary: the second (4) must be the one applied.
    div_load = 1'b1; div_in = 16'd7; edge_adv();
    n_vec++;
    if (load_pend !== 1'b1 || div_cur !== 16'd10) begin
      n_err++; $display("FAIL pend_set: lp=%b div_cur=%0d want 1/10", load_pend, div_cur);
    end
    div_in = 16'd4; d_next = 4; edge_adv(); div_load = 1'b0;
    for (int i = 0; i < 14; i++) begin
      n_vec++;
      if ({tick, mid_tick, clk_out} !== exp_pat(ph, d) || load_pend !== (d != 4) ||
          div_cur !== 16'(d)) begin
        n_err++;
        $display("FAIL deferred ph=%0d d=%0d: outs=%b lp=%b div_cur=%0d want %b/%b/%0d", ph, d,
                 {tick, mid_tick, clk_out}, load_pend, div_cur, exp_pat(ph, d), d != 4, d);
      end
      edge_adv();
    end
  endtask

  task automatic test_load_at_wrap();
    for (int i = 0; i < 40 && ph != 3; i++) edge_adv();
    div_load = 1'b1; div_in = 16'd6; d_next = 6; edge_adv(); div_load = 1'b0;
    for (int i = 0; i < 13; i++) begin
      n_vec++;
      if ({tick, mid_tick, clk_out} !== exp_pat(ph, d) || load_pend !== 1'b0 || div_cur !== 16'd6) begin
        n_err++;
        $display("FAIL load_at_wrap ph=%0d: outs=%b lp=%b div_cur=%0d want %b/0/6", ph,
                 {tick, mid_tick, clk_out}, load_pend, div_cur, exp_pat(ph, d));
      end
      edge_adv();
    end
  endtask

  task automatic test_restart();
    en = 1'b0; div_load = 1'b1; div_in = 16'd10; raw_edge(); div_load = 1'b0;
    en = 1'b1; raw_edge(); ph = 0; d = 10; d_next = 10;
    for (int i = 0; i < 40 && ph != 7; i++) edge_adv();
    restart = 1'b1; raw_edge(); restart = 1'b0; ph = 0;
    for (int i = 0; i < 11; i++) begin
      n_vec++;
      if ({tick, mid_tick, clk_out} !== exp_pat(ph, d)) begin
        n_err++; $display("FAIL restart ph=%0d: outs=%b want %b", ph, {tick, mid_tick, clk_out}, exp_pat(ph, d));
      end
      edge_adv();
    end
    for (int i = 0; i < 40 && ph != 2; i++) edge_adv();
    div_load = 1'b1; div_in = 16'd8; d_next = 8; edge_adv(); div_load = 1'b0;
    for (int i = 0; i < 40 && ph != 5; i++) edge_adv();
    restart = 1'b1; raw_edge(); restart = 1'b0; ph = 0; d = 8;
    n_vec++;
    if (tick !== 1'b1 || clk_out !== 1'b1 || load_pend !== 1'b0 || div_cur !== 16'd8) begin
      n_err++; $display("FAIL restart_apply: tick=%b clk=%b lp=%b div_cur=%0d want 1/1/0/8",
                        tick, clk_out, load_pend, div_cur);
    end
    for (int i = 0; i < 9; i++) begin
      edge_adv();
      n_vec++;
      if ({tick, mid_tick, clk_out} !== exp_pat(ph, d)) begin
        n_err++; $display("FAIL restart_div8 ph=%0d: outs=%b want %b", ph, {tick, mid_tick, clk_out}, exp_pat(ph, d));
      end
    end
  endtask

  task automatic test_stop_pending();
    for (int i = 0; i < 40 && ph != 2; i++) edge_adv();
    div_load = 1'b1; div_in = 16'd3; edge_adv(); div_load = 1'b0;
    en = 1'b0; raw_edge();
    n_vec++;
    if ({tick, mid_tick, clk_out} !== 3'b000 || div_cur !== 16'd3 || load_pend !== 1'b0) begin
      n_err++; $display("FAIL stop_pending: outs=%b div_cur=%0d lp=%b want 000/3/0",
                        {tick, mid_tick, clk_out}, div_cur, load_pend);
    end
  endtask

  task automatic test_clamp_and_rst();
    div_load = 1'b1; div_in = 16'd0; raw_edge();
    n_vec++;
    if (div_cur !== 16'd2) begin n_err++; $display("FAIL clamp0: div_cur=%0d want 2", div_cur); end
    div_in = 16'd1; raw_edge(); div_load = 1'b0;
    n_vec++;
    if (div_cur !== 16'd2) begin n_err++; $display("FAIL clamp1: div_cur=%0d want 2", div_cur); end
    en = 1'b1; raw_edge(); ph = 0; d = 2; d_next = 2;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (clk_out !== ((i % 2) == 0) || {tick, mid_tick, clk_out} !== exp_pat(ph, d)) begin
        n_err++; $display("FAIL div2 i=%0d: outs=%b want %b", i, {tick, mid_tick, clk_out}, exp_pat(ph, d));
      end
      edge_adv();
    end
    // ph is 0 here, so clk_out/tick are high when reset hits mid-cycle.
    #3 rst = 1'b1; #1;
    n_vec++;
    if ({tick, mid_tick, clk_out, load_pend} !== 4'b0000 || div_cur !== 16'd10) begin
      n_err++; $display("FAIL async_rst: outs=%b lp=%b div_cur=%0d want 000/0/10",
                        {tick, mid_tick, clk_out}, load_pend, div_cur);
    end
    raw_edge();
    n_vec++;
    if ({tick, mid_tick, clk_out} !== 3'b000) begin
      n_err++; $display("FAIL rst_hold: outs=%b want 000", {tick, mid_tick, clk_out});
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_div10();
    test_stopped_load();
    test_deferred_load();
    test_load_at_wrap();
    test_restart();
    test_stop_pending();
    test_clamp_and_rst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
